// File: rtl/switch_port_reader.sv
// switch_port_reader: receive-side agent for one switch output port.
// It pulls packets (DA, SA, LEN, LEN payload bytes, FCS) from the switch with
// read strobes and checks the DA and the FCS. Bytes are buffered in a small
// FIFO and streamed downstream with sop/eop/err tags.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   ready               switch has a packet queued on this port
//   read                byte request strobe; port is valid the next cycle
//   port                byte from the switch
//   my_addr             expected destination address for this port
//   out_data/out_valid  first-word-fall-through head of the output FIFO
//   out_ready           downstream accepts when out_valid & out_ready
//   out_sop/out_eop     first byte (DA) / last byte (FCS or abort marker)
//   out_err             {timeout, da_mismatch, fcs_err}, meaningful with out_eop
//   pkt_count/err_count saturating counts of clean / errored packets
module switch_port_reader #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ready,
   output logic             read,
   input  logic [7:0]       port,
   input  logic [7:0]       my_addr,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sop,
   output logic             out_eop,
   output logic [2:0]       out_err,
   output logic [CNT_W-1:0] pkt_count,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned FCNT_W = PTR_W + 1;
   localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);
   // FIFO entry: {data[7:0], sop, eop, err[2:0]}
   localparam int unsigned ENT_W  = 13;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_LENW,
      S_BODY,
      S_DRAIN,
      S_ABORT
   } state_t;

   state_t             state_q;
   logic [1:0]         hdr_cnt_q;
   logic [8:0]         remain_q;
   logic               inflight_q;
   logic [IDLE_W-1:0]  idle_q;
   logic               got_da_q;
   logic               da_mis_q;
   logic [7:0]         xor_q;

   logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [FCNT_W-1:0]  fcnt_q;

   logic [FCNT_W:0]    resv_c;
   logic               rd_permit_c;
   logic               read_c;
   logic               timeout_hit_c;
   logic               land_c;
   logic               da_land_c;
   logic               fcs_land_c;
   logic               abort_push_c;
   logic               push_c;
   logic               pop_c;
   logic [ENT_W-1:0]   push_ent_c;
   logic [ENT_W-1:0]   head_c;
   logic [PTR_W-1:0]   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_d;
   logic [FCNT_W-1:0]  fcnt_d;

   // Read issue: FIFO occupancy plus the byte still in flight reserves space,
   // so a landing byte always has a slot and nothing is ever dropped.
   assign resv_c        = {1'b0, fcnt_q} + (FCNT_W + 1)'(inflight_q);
   assign rd_permit_c   = ((state_q == S_HDR)  && (hdr_cnt_q < 2'd3)) ||
                          ((state_q == S_BODY) && (remain_q != 9'd0));
   assign read_c        = ready && rd_permit_c && (resv_c < (FCNT_W + 1)'(FIFO_DEPTH));
   // read follows the current ready so no strobe is ever issued against an empty queue
   assign read          = read_c;

   assign timeout_hit_c = ((state_q == S_HDR) || (state_q == S_BODY)) && !ready &&
                          (idle_q == IDLE_W'(TIMEOUT - 1));

   // Landing: the byte requested last cycle is on port now
   assign land_c        = inflight_q;
   assign da_land_c     = land_c && !got_da_q;
   assign fcs_land_c    = land_c && (state_q == S_DRAIN);
   // The abort marker is not covered by the read reservation, so wait for room
   assign abort_push_c  = (state_q == S_ABORT) && !inflight_q &&
                          (fcnt_q < FCNT_W'(FIFO_DEPTH));
   assign push_c        = land_c || abort_push_c;
   assign pop_c         = out_valid && out_ready;

   // Entry being written this cycle
   always_comb begin
      push_ent_c = '0;
      if (abort_push_c) begin
         push_ent_c = {8'h00, 1'b0, 1'b1, 1'b1, da_mis_q, 1'b0};
      end else if (land_c) begin
         push_ent_c = {port, da_land_c, fcs_land_c, 1'b0,
                       fcs_land_c & da_mis_q,
                       fcs_land_c & ((xor_q ^ port) != 8'h00)};
      end
   end

   // FIFO pointer/count next state and the head the output register will show
   always_comb begin
      rd_ptr_d = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      fcnt_d   = fcnt_q + FCNT_W'(push_c) - FCNT_W'(pop_c);
      if (fcnt_d == '0) begin
         head_c = '0;
      end else if (push_c && (wr_ptr_q == rd_ptr_d)) begin
         // the entry written now becomes the head: bypass the array
         head_c = push_ent_c;
      end else begin
         head_c = mem_q[rd_ptr_d];
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= push_ent_c;
      end
   end

   // Packet FSM and per-packet state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         hdr_cnt_q  <= 2'd0;
         remain_q   <= 9'd0;
         inflight_q <= 1'b0;
         idle_q     <= '0;
         got_da_q   <= 1'b0;
         da_mis_q   <= 1'b0;
         xor_q      <= 8'h00;
      end else begin
         inflight_q <= read_c;

         if (land_c) begin
            xor_q <= xor_q ^ port;
         end
         if (da_land_c) begin
            got_da_q <= 1'b1;
            da_mis_q <= (port != my_addr);
         end

         // idle counter: any read clears it, ready low while requesting counts up
         if (read_c) begin
            idle_q <= '0;
         end else if (((state_q == S_HDR) || (state_q == S_BODY)) && !ready) begin
            idle_q <= idle_q + IDLE_W'(1);
         end

         case (state_q)
            S_IDLE: begin
               hdr_cnt_q <= 2'd0;
               idle_q    <= '0;
               got_da_q  <= 1'b0;
               da_mis_q  <= 1'b0;
               xor_q     <= 8'h00;
               if (ready) begin
                  state_q <= S_HDR;
               end
            end
            S_HDR: begin
               if (timeout_hit_c) begin
                  state_q <= S_ABORT;
               end else if (read_c) begin
                  hdr_cnt_q <= hdr_cnt_q + 2'd1;
                  if (hdr_cnt_q == 2'd2) begin
                     state_q <= S_LENW;
                  end
               end
            end
            S_LENW: begin
               // LEN lands here; payload plus FCS still to fetch
               if (land_c) begin
                  remain_q <= {1'b0, port} + 9'd1;
                  state_q  <= S_BODY;
               end
            end
            S_BODY: begin
               if (timeout_hit_c) begin
                  state_q <= S_ABORT;
               end else if (read_c) begin
                  remain_q <= remain_q - 9'd1;
                  if (remain_q == 9'd1) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (land_c) begin
                  state_q <= S_IDLE;
               end
            end
            S_ABORT: begin
               if (abort_push_c) begin
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // FIFO pointers, registered head view and packet counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= 8'h00;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_err   <= 3'b000;
         pkt_count <= '0;
         err_count <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         fcnt_q    <= fcnt_d;
         out_valid <= (fcnt_d != '0);
         {out_data, out_sop, out_eop, out_err} <= head_c;

         // packets are counted when their eop entry leaves the FIFO
         if (pop_c && out_eop) begin
            if (out_err != 3'b000) begin
               if (err_count != '1) begin
                  err_count <= err_count + CNT_W'(1);
               end
            end else begin
               if (pkt_count != '1) begin
                  pkt_count <= pkt_count + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_port_reader.sv
// Testbench for switch_port_reader: a switch-side byte server, a downstream
// monitor, and a packet-level reference model of the expected output stream.
module tb_switch_port_reader;

   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned TIMEOUT    = 64;
   localparam int unsigned CNT_W      = 16;
   localparam int          NO_LIMIT   = 32'h7fff_ffff;

   typedef logic [7:0]  byte_q_t [$];
   typedef logic [12:0] ent_t;    // {data, sop, eop, err[2:0]}

   logic             clk       = 1'b0;
   logic             reset     = 1'b1;
   logic             ready     = 1'b0;
   logic             read;
   logic [7:0]       port      = 8'h00;
   logic [7:0]       my_addr   = 8'h00;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic             out_sop;
   logic             out_eop;
   logic [2:0]       out_err;
   logic [CNT_W-1:0] pkt_count;
   logic [CNT_W-1:0] err_count;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [7:0] swq [$];
   int sent_total  = 0;
   int sw_limit    = NO_LIMIT;
   int rd_total    = 0;
   int last_rd_cyc = 0;
   int overreads   = 0;
   int or_mode     = 0;   // 0: always ready, 1: random, 2: hold off

   ent_t obs_q [$];
   int   obs_cyc [$];
   ent_t exp_q [$];
   int   exp_pkt = 0;
   int   exp_err = 0;

   switch_port_reader #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .TIMEOUT   (TIMEOUT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .read     (read),
      .port     (port),
      .my_addr  (my_addr),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sop  (out_sop),
      .out_eop  (out_eop),
      .out_err  (out_err),
      .pkt_count(pkt_count),
      .err_count(err_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Switch side: byte appears on port the cycle after read; ready while bytes remain
   always @(posedge clk) begin
      if (read) begin
         if (swq.size() != 0) port <= swq.pop_front();
         else begin
            port <= 8'hEE;
            overreads = overreads + 1;
         end
         sent_total  = sent_total + 1;
         rd_total    = rd_total + 1;
         last_rd_cyc = cyc;
      end
      ready <= (swq.size() != 0) && (sent_total < sw_limit);
   end

   // Downstream side: choose out_ready for the coming edge, then log the transfer
   always @(negedge clk) begin
      case (or_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
      if (!reset && out_valid && out_ready) begin
         obs_q.push_back({out_data, out_sop, out_eop, out_err});
         obs_cyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) tick();
      swq.delete();
      obs_q.delete();
      obs_cyc.delete();
      exp_q.delete();
      exp_pkt  = 0;
      exp_err  = 0;
      sw_limit = NO_LIMIT;
      reset    = 1'b0;
      tick();
   endtask

   task automatic wait_obs(input int n, input int budget, output bit ok);
      int k = 0;
      while (obs_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      ok = (obs_q.size() >= n);
      repeat (4) tick();
   endtask

   task automatic send(input byte_q_t p);
      foreach (p[i]) swq.push_back(p[i]);
   endtask

   function automatic byte_q_t make_pkt(input logic [7:0] da, input int len, input bit bad);
      byte_q_t p;
      logic [7:0] x;
      p.push_back(da);
      p.push_back(8'($urandom));
      p.push_back(8'(len));
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      x = 8'h00;
      foreach (p[i]) x = x ^ p[i];
      p.push_back(bad ? (x ^ 8'h01) : x);
      return p;
   endfunction

   // Reference model: keep < 0 means full packet, else abort after 'keep' bytes
   function automatic void model_pkt(input byte_q_t p, input logic [7:0] addr, input int keep);
      logic [7:0] x;
      bit da_bad, fcs_bad;
      int n;
      x = 8'h00;
      foreach (p[i]) x = x ^ p[i];
      da_bad  = (p[0] != addr);
      fcs_bad = (x != 8'h00);
      n = p.size();
      if (keep < 0) begin
         for (int i = 0; i < n; i++)
            exp_q.push_back({p[i], 1'(i == 0), 1'(i == n - 1),
                             (i == n - 1) ? {1'b0, da_bad, fcs_bad} : 3'b000});
         if (da_bad || fcs_bad) exp_err++;
         else exp_pkt++;
      end else begin
         for (int i = 0; i < keep; i++)
            exp_q.push_back({p[i], 1'(i == 0), 1'b0, 3'b000});
         exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1, 1'(keep > 0 && da_bad), 1'b0});
         exp_err++;
      end
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read got %b need 0", read); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b need 0", out_valid); end
      checks++; if (out_sop !== 1'b0 || out_eop !== 1'b0) begin errors++; $display("FAIL reset_sop_eop got %b%b need 00", out_sop, out_eop); end
      checks++; if (out_err !== 3'b000) begin errors++; $display("FAIL reset_out_err got %b need 000", out_err); end
      checks++; if (pkt_count !== '0 || err_count !== '0) begin errors++; $display("FAIL reset_counts got %0d/%0d need 0/0", pkt_count, err_count); end
      reset = 1'b0;
      tick();
   endtask

   // Directed single packet; name selects the scenario's FAIL tag
   task automatic test_directed(input string name, input logic [7:0] addr, input byte_q_t p,
                                input int need_pkt, input int need_err);
      bit ok;
      int rd0;
      do_reset();
      my_addr = addr;
      or_mode = 0;
      rd0 = rd_total;
      model_pkt(p, addr, -1);
      send(p);
      wait_obs(exp_q.size(), 200, ok);
      checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count got %0d need %0d", name, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_entry[%0d] got %h need %h", name, i, (i < obs_q.size()) ? obs_q[i] : 13'h0, exp_q[i]); end
      end
      checks++; if (rd_total - rd0 != p.size()) begin errors++; $display("FAIL %s_reads got %0d need %0d", name, rd_total - rd0, p.size()); end
      checks++; if (pkt_count !== CNT_W'(need_pkt) || err_count !== CNT_W'(need_err)) begin errors++; $display("FAIL %s_counters got %0d/%0d need %0d/%0d", name, pkt_count, err_count, need_pkt, need_err); end
   endtask

   task automatic test_backpressure();
      bit ok;
      int rd0;
      byte_q_t p;
      do_reset();
      my_addr = 8'h3C;
      or_mode = 2;
      tick();
      rd0 = rd_total;
      p = make_pkt(my_addr, 10, 1'b0);
      model_pkt(p, my_addr, -1);
      send(p);
      repeat (40) tick();
      checks++; if (rd_total - rd0 != FIFO_DEPTH) begin errors++; $display("FAIL bp_stall_reads got %0d need %0d", rd_total - rd0, FIFO_DEPTH); end
      checks++; if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== p[0]) begin errors++; $display("FAIL bp_head got v%b s%b %h need v1 s1 %h", out_valid, out_sop, out_data, p[0]); end
      or_mode = 0;
      wait_obs(exp_q.size(), 200, ok);
      checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d need %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_entry[%0d] got %h need %h", i, (i < obs_q.size()) ? obs_q[i] : 13'h0, exp_q[i]); end
      end
      checks++; if (rd_total - rd0 != 14) begin errors++; $display("FAIL bp_reads got %0d need 14", rd_total - rd0); end
   endtask

   task automatic test_timeout();
      bit ok;
      int rd0, gap;
      byte_q_t p;
      do_reset();
      my_addr = 8'h5A;
      or_mode = 0;
      rd0 = rd_total;
      p = make_pkt(my_addr, 5, 1'b0);
      sw_limit = sent_total + 2;
      model_pkt(p, my_addr, 2);
      send(p);
      wait_obs(3, TIMEOUT + 60, ok);
      checks++; if (!ok || obs_q.size() != 3) begin errors++; $display("FAIL to_count got %0d need 3", obs_q.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL to_entry[%0d] got %h need %h", i, (i < obs_q.size()) ? obs_q[i] : 13'h0, exp_q[i]); end
      end
      checks++; if (rd_total - rd0 != 2) begin errors++; $display("FAIL to_reads got %0d need 2", rd_total - rd0); end
      gap = (obs_cyc.size() >= 3) ? obs_cyc[2] - last_rd_cyc : -1;
      checks++; if (gap < TIMEOUT + 1 || gap > TIMEOUT + 3) begin errors++; $display("FAIL to_latency got %0d need %0d..%0d", gap, TIMEOUT + 1, TIMEOUT + 3); end
      checks++; if (err_count !== CNT_W'(1) || pkt_count !== '0) begin errors++; $display("FAIL to_counters got %0d/%0d need 0/1", pkt_count, err_count); end
      // the rest of the aborted packet is discarded at the switch; next one must be clean
      swq.delete();
      sw_limit = NO_LIMIT;
      repeat (3) tick();
      p = make_pkt(my_addr, 3, 1'b0);
      model_pkt(p, my_addr, -1);
      send(p);
      wait_obs(exp_q.size(), 200, ok);
      checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL to_next_count got %0d need %0d", obs_q.size(), exp_q.size()); end
      for (int i = 3; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL to_next_entry[%0d] got %h need %h", i, (i < obs_q.size()) ? obs_q[i] : 13'h0, exp_q[i]); end
      end
      checks++; if (pkt_count !== CNT_W'(1) || err_count !== CNT_W'(1)) begin errors++; $display("FAIL to_next_counters got %0d/%0d need 1/1", pkt_count, err_count); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int rd0, k;
      byte_q_t p;
      do_reset();
      my_addr = 8'hA7;
      or_mode = 0;
      p = make_pkt(my_addr, 2, 1'b0);
      model_pkt(p, my_addr, -1);
      send(p);
      wait_obs(exp_q.size(), 200, ok);
      checks++; if (pkt_count !== CNT_W'(1)) begin errors++; $display("FAIL rm_pre_count got %0d need 1", pkt_count); end
      rd0 = rd_total;
      send(make_pkt(my_addr, 5, 1'b0));
      k = 0;
      while (rd_total - rd0 < 5 && k < 50) begin tick(); k++; end
      checks++; if (rd_total - rd0 < 5) begin errors++; $display("FAIL rm_reach_body got %0d reads need 5", rd_total - rd0); end
      #2 reset = 1'b1;
      #1;
      checks++; if (read !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_outputs got read%b valid%b need 0 0", read, out_valid); end
      checks++; if (pkt_count !== '0 || err_count !== '0) begin errors++; $display("FAIL rm_counters got %0d/%0d need 0/0", pkt_count, err_count); end
      do_reset();
      p = make_pkt(my_addr, 4, 1'b0);
      model_pkt(p, my_addr, -1);
      send(p);
      wait_obs(exp_q.size(), 200, ok);
      checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rm_after_count got %0d need %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rm_after_entry[%0d] got %h need %h", i, (i < obs_q.size()) ? obs_q[i] : 13'h0, exp_q[i]); end
      end
      checks++; if (pkt_count !== CNT_W'(1) || err_count !== '0) begin errors++; $display("FAIL rm_after_counters got %0d/%0d need 1/0", pkt_count, err_count); end
   endtask

   // Several packets queued at once; mode 0 checks throughput, mode 1 random backpressure
   task automatic test_stream(input string name, input int mode, input int npkt, input int maxlen);
      bit ok;
      int rd0, t0, bytes;
      byte_q_t p;
      logic [7:0] da;
      do_reset();
      my_addr = 8'($urandom);
      or_mode = mode;
      rd0 = rd_total;
      bytes = 0;
      for (int n = 0; n < npkt; n++) begin
         da = ($urandom_range(0, 2) != 0) ? my_addr : (my_addr ^ 8'($urandom_range(1, 255)));
         p = make_pkt(da, $urandom_range(0, maxlen), ($urandom_range(0, 3) == 0));
         model_pkt(p, my_addr, -1);
         send(p);
         bytes += p.size();
      end
      t0 = cyc;
      wait_obs(exp_q.size(), 6000, ok);
      checks++; if (!ok || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL %s_count got %0d need %0d", name, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL %s_entry[%0d] got %h need %h", name, i, (i < obs_q.size()) ? obs_q[i] : 13'h0, exp_q[i]); end
      end
      checks++; if (rd_total - rd0 != bytes) begin errors++; $display("FAIL %s_reads got %0d need %0d", name, rd_total - rd0, bytes); end
      checks++; if (pkt_count !== CNT_W'(exp_pkt) || err_count !== CNT_W'(exp_err)) begin errors++; $display("FAIL %s_counters got %0d/%0d need %0d/%0d", name, pkt_count, err_count, exp_pkt, exp_err); end
      if (mode == 0 && obs_cyc.size() != 0) begin
         checks++;
         if (obs_cyc[obs_cyc.size() - 1] - t0 > bytes + 3 * npkt + 8) begin errors++; $display("FAIL %s_throughput got %0d cycles need <= %0d", name, obs_cyc[obs_cyc.size() - 1] - t0, bytes + 3 * npkt + 8); end
      end
      checks++; if (overreads != 0) begin errors++; $display("FAIL %s_overreads got %0d need 0", name, overreads); end
   endtask

   initial begin
      test_reset();
      test_directed("basic",    8'h55, '{8'h55, 8'h11, 8'h02, 8'hA0, 8'hA1, 8'h47}, 1, 0);
      test_directed("fcs_err",  8'h55, '{8'h55, 8'h11, 8'h02, 8'hA0, 8'hA1, 8'h48}, 0, 1);
      test_directed("da_mis",   8'h66, '{8'h55, 8'h11, 8'h00, 8'h44}, 0, 1);
      test_backpressure();
      test_timeout();
      test_reset_mid();
      test_stream("back_to_back", 0, 3, 8);
      test_stream("random", 1, 15, 24);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_port_reader.md
Name: switch_port_reader

Overview:
- Receive-side agent for one switch output port; the consumer end of the ready/read/port handshake that the switch drives on each of its four output ports.
- Sees ready, issues read strobes, captures packet bytes, checks destination address and FCS.
- Buffers bytes in a small FIFO and streams them downstream with sop/eop/error tags.
- One instance per output port; also used as the reusable RTL sink in the switch verification environment.

Parameters:
FIFO_DEPTH, 8, byte entries in output FIFO (power of 2, >=4)
TIMEOUT, 64, cycles ready may stay low mid-packet before abort
CNT_W, 16, width of pkt_count / err_count

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
ready  in  1  switch has a packet queued on this port
read  out  1  byte request strobe to switch
port  in  8  byte from switch, valid exactly 1 cycle after each cycle read=1
my_addr  in  8  expected DA for this port (static during a packet)
out_data  out  8  streamed byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts when out_valid&out_ready
out_sop  out  1  first byte (DA)
out_eop  out  1  last byte (FCS, or abort marker)
out_err  out  3  {timeout, da_mismatch, fcs_err}, valid only with out_eop
pkt_count  out  CNT_W  packets ended without error, saturating
err_count  out  CNT_W  packets ended with any error, saturating

Behaviour:
- Packet: DA, SA, LEN, LEN payload bytes, FCS; total LEN+4 bytes. FCS = XOR of all preceding bytes. LEN 0..255.
- Reset (async assert, sync release): read=0, out_valid=0, out_sop=0, out_eop=0, out_err=0, counters=0, FIFO empty, state IDLE.
- Read issue rule: read=1 only if ready=1, state permits, and fifo_count + inflight < FIFO_DEPTH. inflight counts reads whose byte has not yet landed (0 or 1).
- FSM:
  - IDLE: ready=1 -> HDR.
  - HDR: issue exactly 3 reads (DA, SA, LEN) -> LENW.
  - LENW: wait until LEN byte lands; remaining = LEN+1 (9-bit) -> BODY.
  - BODY: issue reads until remaining=0 -> DRAIN.
  - DRAIN: wait for the last byte (FCS) to land -> IDLE. The FCS byte is written to the FIFO with eop=1 and the err bits.
- Landing: each byte is captured the cycle after its read. It is pushed into the FIFO with sop=1 on DA. A running XOR accumulates every byte.
- da_mismatch: DA != my_addr. The packet is still fully drained and forwarded.
- fcs_err: running XOR, including the FCS byte, is nonzero.
- Timeout:
  - In HDR or BODY, an idle counter increments each cycle ready=0; it clears on any read.
  - At TIMEOUT: stop reads, wait for inflight to land, then push one abort entry: data 0x00, eop=1, timeout bit=1, plus da_mismatch if DA was received. Then go to IDLE.
  - No further bytes of that packet are requested.
- FIFO full: reads stall and the switch holds the byte. No byte is ever dropped; inflight reservation guarantees space.
- FIFO push/pop in the same cycle is allowed when full or empty per standard rules. out_* is a registered view of the FIFO head (first-word fall-through); latency is 1 cycle from push to out_valid.
- Counters update on the cycle the eop entry pops, not when it is pushed. Both counters saturate at all-ones.
- Back-to-back packets: IDLE->HDR may occur on the cycle after DRAIN completes; minimum gap is 1 cycle.
- Reset mid-packet: everything clears immediately. The partial packet is lost and no eop is emitted.

Test Plan:
- my_addr=0x55; switch sends 55 11 02 A0 A1 47, out_ready=1. Expect 6 bytes, sop on 0x55, eop on 0x47, out_err=000, pkt_count=1, read high exactly 6 cycles.
- Same packet with FCS byte 0x48. Expect eop with out_err=001, err_count=1, pkt_count=0.
- my_addr=0x66, correct packet 55 11 00 44. Expect 4 bytes forwarded, out_err=010 on eop.
- LEN=10 packet with out_ready=0 for 40 cycles. Expect read to stop after FIFO_DEPTH reservations (8). Release out_ready; expect all 14 bytes in order, no loss, no duplicates.
- Drop ready after SA with TIMEOUT=64. Expect no read for 64 cycles, then an abort entry 0x00, eop, out_err=100, err_count=1, state IDLE.
- Assert reset during BODY of a LEN=5 packet. Expect read=0 and out_valid=0 immediately, counters 0. A subsequent clean packet is received correctly.
